// File: rtl/wallclock_pkg.sv
`default_nettype none
//==============================================================================
// Module   : wallclock_pkg
// Brief    : Shared mode encodings and BCD helpers for the wall-clock controller.
// Revision : 1.0 - initial release
//==============================================================================
package wallclock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'b00,
      MODE_SET_HOUR = 2'b01,
      MODE_SET_MIN  = 2'b10,
      MODE_SET_SEC  = 2'b11
   } mode_e;

   localparam logic [7:0] BCD_MAX_59 = 8'h59;

   function automatic logic [7:0] bcd_max(input int hour_mod);
      return (hour_mod == 12) ? 8'h11 : 8'h23;
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                return {v[7:4], v[3:0] - 4'd1};
   endfunction

   // Blink-mask bit ({hour,min,sec}) of the field edited in a given mode.
   function automatic logic [2:0] mode_field(input mode_e m);
      case (m)
         MODE_SET_HOUR: return 3'b100;
         MODE_SET_MIN:  return 3'b010;
         MODE_SET_SEC:  return 3'b001;
         default:       return 3'b000;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
//==============================================================================
// Module   : bcd_mod_counter
// Brief    : Two-digit BCD up/down counter, range 00..MAX_BCD, wrapping both ways.
// Revision : 1.0 - initial release
//==============================================================================
module bcd_mod_counter
   import wallclock_pkg::*;
#(
   parameter logic [7:0] MAX_BCD = BCD_MAX_59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] q,
   output logic       wrap
);

   logic [7:0] r_q;
   logic       r_wrap;

   // Simultaneous inc and dec cancel out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q    <= 8'h00;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (inc && !dec) begin
            if (r_q == MAX_BCD) begin
               r_q    <= 8'h00;
               r_wrap <= 1'b1;
            end else begin
               r_q <= bcd_inc(r_q);
            end
         end else if (dec && !inc) begin
            r_q <= (r_q == 8'h00) ? MAX_BCD : bcd_dec(r_q);
         end
      end
   end

   assign q    = r_q;
   assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: rtl/wallclock_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : wallclock_ctrl
// Brief    : Wall-clock timekeeping: sec/min/hour BCD chain, set-time FSM, blink.
// Revision : 1.0 - initial release
//==============================================================================
module wallclock_ctrl
   import wallclock_pkg::*;
#(
   parameter int HOUR_MOD     = 24,
   parameter int BLINK_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] hour_bcd,
   output logic [1:0] mode,
   output logic [2:0] blink_mask,
   output logic       sec_carry,
   output logic       min_carry
);

   localparam int                   c_blink_w    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_CYCLES - 1);

   mode_e                r_mode;
   logic [c_blink_w-1:0] r_blink_cnt;
   logic                 r_phase;
   logic [2:0]           r_blink_mask;
   logic                 r_sec_carry;
   logic                 r_min_carry;

   logic w_run_tick, w_adj_inc, w_adj_dec, w_sec_top, w_min_top;
   logic w_sec_inc, w_sec_dec, w_min_inc, w_min_dec, w_hour_inc, w_hour_dec;
   logic w_blink_restart;
   logic w_sec_wrap_unused, w_min_wrap_unused, w_hour_wrap_unused;

   // A mode press overrides inc/dec; inc together with dec is discarded.
   assign w_run_tick = tick_1hz && (r_mode == MODE_RUN);
   assign w_adj_inc  = (r_mode != MODE_RUN) && btn_inc && !btn_dec && !btn_mode;
   assign w_adj_dec  = (r_mode != MODE_RUN) && btn_dec && !btn_inc && !btn_mode;
   assign w_sec_top  = (sec_bcd == BCD_MAX_59);
   assign w_min_top  = (min_bcd == BCD_MAX_59);

   assign w_sec_inc  = w_run_tick || (w_adj_inc && r_mode == MODE_SET_SEC);
   assign w_sec_dec  = w_adj_dec && (r_mode == MODE_SET_SEC);
   assign w_min_inc  = (w_run_tick && w_sec_top) || (w_adj_inc && r_mode == MODE_SET_MIN);
   assign w_min_dec  = w_adj_dec && (r_mode == MODE_SET_MIN);
   assign w_hour_inc = (w_run_tick && w_sec_top && w_min_top) ||
                       (w_adj_inc && r_mode == MODE_SET_HOUR);
   assign w_hour_dec = w_adj_dec && (r_mode == MODE_SET_HOUR);

   assign w_blink_restart = btn_mode || btn_inc || btn_dec || (r_mode == MODE_RUN);

   bcd_mod_counter #(.MAX_BCD(BCD_MAX_59)) u_sec (
      .clk(clk), .reset(reset), .inc(w_sec_inc), .dec(w_sec_dec),
      .q(sec_bcd), .wrap(w_sec_wrap_unused)
   );

   bcd_mod_counter #(.MAX_BCD(BCD_MAX_59)) u_min (
      .clk(clk), .reset(reset), .inc(w_min_inc), .dec(w_min_dec),
      .q(min_bcd), .wrap(w_min_wrap_unused)
   );

   bcd_mod_counter #(.MAX_BCD(bcd_max(HOUR_MOD))) u_hour (
      .clk(clk), .reset(reset), .inc(w_hour_inc), .dec(w_hour_dec),
      .q(hour_bcd), .wrap(w_hour_wrap_unused)
   );

   // Carries come from the run-mode chain only, so set-mode wraps never pulse them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode       <= MODE_RUN;
         r_blink_cnt  <= '0;
         r_phase      <= 1'b0;
         r_blink_mask <= 3'b000;
         r_sec_carry  <= 1'b0;
         r_min_carry  <= 1'b0;
      end else begin
         r_sec_carry <= w_run_tick && w_sec_top;
         r_min_carry <= w_run_tick && w_sec_top && w_min_top;

         if (btn_mode) begin
            unique case (r_mode)
               MODE_RUN:      r_mode <= MODE_SET_HOUR;
               MODE_SET_HOUR: r_mode <= MODE_SET_MIN;
               MODE_SET_MIN:  r_mode <= MODE_SET_SEC;
               MODE_SET_SEC:  r_mode <= MODE_RUN;
            endcase
         end

         // Restart shows the field; mode is stable whenever the phase toggles.
         if (w_blink_restart) begin
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
            r_blink_mask <= 3'b000;
         end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt  <= '0;
            r_phase      <= !r_phase;
            r_blink_mask <= r_phase ? 3'b000 : mode_field(r_mode);
         end else begin
            r_blink_cnt  <= r_blink_cnt + 1'b1;
         end
      end
   end

   assign mode       = r_mode;
   assign blink_mask = r_blink_mask;
   assign sec_carry  = r_sec_carry;
   assign min_carry  = r_min_carry;

endmodule
`default_nettype wire
